// File: rtl/rx_pkt_classifier.sv
// rx_pkt_classifier: store-and-forward frame buffer in front of the lookup block.
// Good frames trigger one tagged lookup request; results (in request order) release
// frames for replay on m_axis with outport/seek_flag held as sideband per frame.
module rx_pkt_classifier #(
    parameter int P_BUF_AW        = 9,
    parameter int P_MAX_PKT_BEATS = 192,
    parameter int P_META_DEPTH    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        rx_axis_tvalid,
    input  logic [63:0] rx_axis_tdata,
    input  logic        rx_axis_tlast,
    input  logic [7:0]  rx_axis_tkeep,
    input  logic        rx_axis_tuser,
    output logic        rx_axis_tready,
    output logic [47:0] o_check_mac,
    output logic [3:0]  o_check_id,
    output logic        o_check_valid,
    input  logic [2:0]  i_outport,
    input  logic [1:0]  i_seek_flag,
    input  logic [3:0]  i_check_id,
    input  logic        i_result_valid,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tkeep,
    input  logic        m_axis_tready,
    output logic [2:0]  o_outport,
    output logic [1:0]  o_seek_flag,
    output logic [15:0] o_drop_cnt,
    output logic [15:0] o_err_cnt
);
    localparam int MW = $clog2(P_META_DEPTH);
    localparam logic [P_BUF_AW:0] C_DEPTH  = {1'b1, {P_BUF_AW{1'b0}}};
    localparam logic [P_BUF_AW:0] C_MAXB   = P_MAX_PKT_BEATS[P_BUF_AW:0];
    localparam logic [MW:0]       C_MDEPTH = {1'b1, {MW{1'b0}}};

    typedef enum logic {S_IDLE, S_SEND} state_t;
    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    // storage (no reset)
    beat_t             mem_q      [2**P_BUF_AW];
    logic [P_BUF_AW:0] end_mem_q  [P_META_DEPTH];
    logic [4:0]        meta_mem_q [P_META_DEPTH];

    // write side
    logic [P_BUF_AW:0] wr_ptr_q, sof_ptr_q, rd_ptr_q, used, free;
    logic              in_frame_q;
    logic [47:0]       mac_q;
    logic [3:0]        tag_q, exp_tag_q;
    logic [MW:0]       ccnt_q, end_wp_q, meta_wp_q, rp_q;
    logic              rx_hs, rx_good, rx_bad, meta_empty;

    // read side
    state_t            state_q, state_d;
    logic              fsm_pop, fetch, fetch_act_q, fetch_last, out_pop, push_hi;
    logic [P_BUF_AW:0] fptr_q, end_q, fetch_end;
    beat_t [1:0]       ent_q;
    logic [1:0]        ocnt_q;

    // Free space counts beats not yet handed downstream, so it stays conservative
    // while the fetch pointer runs ahead into the output stage.
    assign used       = wr_ptr_q - rd_ptr_q;
    assign free       = C_DEPTH - used;
    assign rx_axis_tready = in_frame_q | ((free >= C_MAXB) & (ccnt_q < C_MDEPTH));
    assign rx_hs      = rx_axis_tvalid & rx_axis_tready;
    assign rx_good    = rx_hs & rx_axis_tlast & ~rx_axis_tuser;
    assign rx_bad     = rx_hs & rx_axis_tlast & rx_axis_tuser;
    assign meta_empty = (meta_wp_q == rp_q);

    assign out_pop    = (ocnt_q != 2'd0) & m_axis_tready;
    assign fetch_end  = fsm_pop ? end_mem_q[rp_q[MW-1:0]] : end_q;
    assign fetch      = (fetch_act_q | fsm_pop) & ((ocnt_q != 2'd2) | out_pop);
    assign fetch_last = (fptr_q == fetch_end);
    // Incoming beat lands in the skid slot when the head stays occupied.
    assign push_hi    = ((ocnt_q == 2'd1) & ~out_pop) | (ocnt_q == 2'd2);

    assign m_axis_tvalid = (ocnt_q != 2'd0);
    assign m_axis_tdata  = ent_q[0].data;
    assign m_axis_tkeep  = ent_q[0].keep;
    assign m_axis_tlast  = ent_q[0].last;

    // Buffer and FIFO array writes.
    always_ff @(posedge i_clk) begin
        if (rx_hs)
            mem_q[wr_ptr_q[P_BUF_AW-1:0]] <= {rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};
        if (rx_good)
            end_mem_q[end_wp_q[MW-1:0]] <= wr_ptr_q;
        if (i_result_valid)
            meta_mem_q[meta_wp_q[MW-1:0]] <= {i_outport, i_seek_flag};
    end

    // Write side: frame tracking, commit/rewind, lookup request, drop count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q      <= '0;
            sof_ptr_q     <= '0;
            in_frame_q    <= 1'b0;
            mac_q         <= '0;
            tag_q         <= '0;
            end_wp_q      <= '0;
            o_check_valid <= 1'b0;
            o_check_mac   <= '0;
            o_check_id    <= '0;
            o_drop_cnt    <= '0;
        end else begin
            o_check_valid <= 1'b0;
            if (rx_hs) begin
                in_frame_q <= ~rx_axis_tlast;
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                if (!in_frame_q) begin
                    sof_ptr_q <= wr_ptr_q;
                    mac_q     <= rx_axis_tdata[63:16];
                end
            end
            if (rx_bad) begin
                wr_ptr_q <= in_frame_q ? sof_ptr_q : wr_ptr_q;
                if (o_drop_cnt != 16'hFFFF)
                    o_drop_cnt <= o_drop_cnt + 1'b1;
            end
            if (rx_good) begin
                end_wp_q      <= end_wp_q + 1'b1;
                o_check_valid <= 1'b1;
                o_check_mac   <= in_frame_q ? mac_q : rx_axis_tdata[63:16];
                o_check_id    <= tag_q;
                tag_q         <= tag_q + 1'b1;
            end
        end
    end

    // Result intake: queue sideband, count tag mismatches but still use the result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_wp_q <= '0;
            exp_tag_q <= '0;
            o_err_cnt <= '0;
        end else if (i_result_valid) begin
            meta_wp_q <= meta_wp_q + 1'b1;
            exp_tag_q <= exp_tag_q + 1'b1;
            if (i_check_id != exp_tag_q && o_err_cnt != 16'hFFFF)
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

    // Output FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Output FSM next state: start a frame when a result is queued, end on tlast handshake.
    always_comb begin
        state_d = state_q;
        fsm_pop = 1'b0;
        case (state_q)
            S_IDLE: if (!meta_empty) begin
                fsm_pop = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: if (out_pop && ent_q[0].last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read side: frame release, fetch pointer, output register + skid, sideband.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rp_q        <= '0;
            ccnt_q      <= '0;
            fptr_q      <= '0;
            end_q       <= '0;
            fetch_act_q <= 1'b0;
            rd_ptr_q    <= '0;
            ent_q       <= '0;
            ocnt_q      <= '0;
            o_outport   <= '0;
            o_seek_flag <= '0;
        end else begin
            ccnt_q <= ccnt_q + {{MW{1'b0}}, rx_good} - {{MW{1'b0}}, fsm_pop};
            if (fsm_pop) begin
                rp_q        <= rp_q + 1'b1;
                end_q       <= fetch_end;
                o_outport   <= meta_mem_q[rp_q[MW-1:0]][4:2];
                o_seek_flag <= meta_mem_q[rp_q[MW-1:0]][1:0];
            end
            if (fetch) begin
                fptr_q      <= fptr_q + 1'b1;
                fetch_act_q <= ~fetch_last;
            end
            if (out_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                ent_q[0] <= ent_q[1];
            end
            if (fetch)
                ent_q[push_hi] <= mem_q[fptr_q[P_BUF_AW-1:0]];
            ocnt_q <= ocnt_q + {1'b0, fetch} - {1'b0, out_pop};
        end
    end
endmodule
